// File: rtl/led_panel_cmd_tx.sv
// LED panel command transmitter: encodes drawing requests into the panel byte
// protocol and serialises each byte as 8N1 UART on uart_tx.
module led_panel_cmd_tx #(
    parameter int unsigned CLKS_PER_BIT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_rgb,
    input  logic [3:0] cmd_col,
    input  logic [3:0] cmd_row,
    output logic       uart_tx,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    typedef enum logic [2:0] {
        OP_SET_RGB      = 3'd0,
        OP_SET_PIXEL    = 3'd1,
        OP_CLR_PIXEL    = 3'd2,
        OP_CLEAR_SCREEN = 3'd3,
        OP_RESYNC       = 3'd4
    } op_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_n;
    logic [15:0] bit_cnt_q, bit_cnt_n;
    logic [2:0]  bit_idx_q, bit_idx_n;
    logic        byte_idx_q, byte_idx_n;
    logic [7:0]  byte0_q, byte0_n;
    logic [7:0]  byte1_q, byte1_n;
    logic        two_q, two_n;
    logic        err_q, err_n;

    logic [7:0]  enc_b0, enc_b1, pixel, cur_byte;
    logic        enc_two, enc_reject, accept, period_done;

    assign pixel       = {cmd_col, cmd_row};
    assign accept      = cmd_valid && cmd_ready;
    assign period_done = (bit_cnt_q == LAST_CNT);
    assign cur_byte    = byte_idx_q ? byte1_q : byte0_q;

    // Pixel byte 0xFF collides with RESYNC at the receiver, so col=15,row=15 is unreachable.
    always_comb begin
        enc_b0     = '0;
        enc_b1     = '0;
        enc_two    = 1'b0;
        enc_reject = 1'b0;
        case (cmd_op)
            OP_SET_RGB:      enc_b0 = {5'b00000, cmd_rgb};
            OP_SET_PIXEL: begin
                enc_b0     = 8'h10;
                enc_b1     = pixel;
                enc_two    = 1'b1;
                enc_reject = (pixel == 8'hFF);
            end
            OP_CLR_PIXEL: begin
                enc_b0     = 8'h20;
                enc_b1     = pixel;
                enc_two    = 1'b1;
                enc_reject = (pixel == 8'hFF);
            end
            OP_CLEAR_SCREEN: enc_b0 = 8'h30;
            OP_RESYNC:       enc_b0 = 8'hFF;
            default:         enc_reject = 1'b1;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        bit_idx_n  = bit_idx_q;
        byte_idx_n = byte_idx_q;
        byte0_n    = byte0_q;
        byte1_n    = byte1_q;
        two_n      = two_q;
        err_n      = 1'b0;

        if (state_q == S_IDLE) begin
            bit_cnt_n  = '0;
            bit_idx_n  = '0;
            byte_idx_n = 1'b0;
            if (accept) begin
                err_n = enc_reject;
                if (!enc_reject) begin
                    state_n = S_START;
                    byte0_n = enc_b0;
                    byte1_n = enc_b1;
                    two_n   = enc_two;
                end
            end
        end else begin
            bit_cnt_n = period_done ? '0 : bit_cnt_q + 16'd1;
            if (period_done) begin
                case (state_q)
                    S_START: state_n = S_DATA;
                    S_DATA: begin
                        bit_idx_n = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_n = S_STOP;
                    end
                    S_STOP: begin
                        // Second byte starts straight after the first stop bit.
                        if (two_q && !byte_idx_q) begin
                            state_n    = S_START;
                            byte_idx_n = 1'b1;
                        end else begin
                            state_n    = S_IDLE;
                            byte_idx_n = 1'b0;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= 1'b0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            two_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            bit_idx_q  <= bit_idx_n;
            byte_idx_q <= byte_idx_n;
            byte0_q    <= byte0_n;
            byte1_q    <= byte1_n;
            two_q      <= two_n;
            err_q      <= err_n;
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state_q)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = cur_byte[bit_idx_q];
            default: uart_tx = 1'b1;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_led_panel_cmd_tx.sv
// Directed bench for led_panel_cmd_tx: checks serial waveforms cycle by cycle
// against hand-derived 8N1 frames for both CLKS_PER_BIT=20 and 2 builds.
module tb_led_panel_cmd_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_rgb = '0;
    logic [3:0] cmd_col = '0;
    logic [3:0] cmd_row = '0;
    logic       cmd_ready, uart_tx, busy, err;
    logic       ready2, tx2, busy2, err2;

    int checks = 0;
    int passed = 0;

    led_panel_cmd_tx dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rgb(cmd_rgb), .cmd_col(cmd_col), .cmd_row(cmd_row),
        .uart_tx(uart_tx), .busy(busy), .err(err)
    );

    led_panel_cmd_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready2),
        .cmd_op(cmd_op), .cmd_rgb(cmd_rgb), .cmd_col(cmd_col), .cmd_row(cmd_row),
        .uart_tx(tx2), .busy(busy2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] put_byte(input logic [511:0] w, input int start,
                                              input logic [7:0] b, input int cpb);
        logic [511:0] r = w;
        logic bv;
        for (int k = 0; k < 10; k++) begin
            bv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int c = 0; c < cpb; c++) r[start + k*cpb + c] = bv;
        end
        return r;
    endfunction

    function automatic logic [511:0] ones(input int n);
        logic [511:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic capture(input int n, input bit sel, output logic [511:0] tx_v,
                           output logic [511:0] busy_v, output logic [511:0] err_v);
        tx_v = '1; busy_v = '0; err_v = '0;
        for (int i = 0; i < n; i++) begin
            tx_v[i]   = sel ? tx2 : uart_tx;
            busy_v[i] = sel ? busy2 : busy;
            err_v[i]  = sel ? err2 : err;
            step();
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
    endtask

    task automatic send_req(input logic [2:0] op, input logic [2:0] rgb,
                            input logic [3:0] col, input logic [3:0] row);
        wait_ready();
        cmd_op = op; cmd_rgb = rgb; cmd_col = col; cmd_row = row;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else passed++;
        reset = 1'b0;
        step();
        checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_set_rgb();
        logic [511:0] tv, bv, ev, et;
        send_req(3'd0, 3'b101, 4'd0, 4'd0);
        capture(200, 1'b0, tv, bv, ev);
        et = put_byte('1, 0, 8'h05, 20);
        checks++; if (tv !== et) $display("FAIL rgb_wave: got %h want %h", tv, et); else passed++;
        checks++; if (bv !== ones(200)) $display("FAIL rgb_busy: got %h want %h", bv, ones(200)); else passed++;
        checks++; if (ev !== '0) $display("FAIL rgb_err: got %h want 0", ev); else passed++;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rgb_ready_return: ready=%b busy=%b want 1/0", cmd_ready, busy); else passed++;
    endtask

    task automatic test_set_pixel();
        logic [511:0] tv, bv, ev, et;
        send_req(3'd1, 3'd0, 4'd14, 4'd2);
        capture(400, 1'b0, tv, bv, ev);
        et = put_byte(put_byte('1, 0, 8'h10, 20), 200, 8'hE2, 20);
        checks++; if (tv !== et) $display("FAIL pixel_wave: got %h want %h", tv, et); else passed++;
        checks++; if (bv !== ones(400)) $display("FAIL pixel_busy: got %h want %h", bv, ones(400)); else passed++;
        checks++; if (ev !== '0) $display("FAIL pixel_err: got %h want 0", ev); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL pixel_ready_return: got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_reject();
        logic [2:0] ops [2] = '{3'd1, 3'd6};
        logic [511:0] tv, bv, ev, et;
        for (int i = 0; i < 2; i++) begin
            wait_ready();
            cmd_op = ops[i]; cmd_col = 4'd15; cmd_row = 4'd15; cmd_rgb = 3'd0;
            cmd_valid = 1'b1;
            step();
            checks++; if (err !== 1'b1) $display("FAIL rej%0d_err: got %b want 1", i, err); else passed++;
            checks++; if (uart_tx !== 1'b1) $display("FAIL rej%0d_tx: got %b want 1", i, uart_tx); else passed++;
            checks++; if (cmd_ready !== 1'b1) $display("FAIL rej%0d_ready: got %b want 1", i, cmd_ready); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL rej%0d_busy: got %b want 0", i, busy); else passed++;
            cmd_op = 3'd3;
            step();
            cmd_valid = 1'b0;
            checks++; if (err !== 1'b0) $display("FAIL rej%0d_err_len: got %b want 0", i, err); else passed++;
            checks++; if (uart_tx !== 1'b0) $display("FAIL rej%0d_next_start: got %b want 0", i, uart_tx); else passed++;
            capture(200, 1'b0, tv, bv, ev);
            et = put_byte('1, 0, 8'h30, 20);
            checks++; if (tv !== et) $display("FAIL rej%0d_clear_wave: got %h want %h", i, tv, et); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] tv, et;
        int hs = 0;
        int hs_cyc = -1;
        wait_ready();
        cmd_op = 3'd3; cmd_valid = 1'b1;
        step();
        cmd_op = 3'd4;
        tv = '1;
        for (int i = 0; i < 401; i++) begin
            tv[i] = uart_tx;
            if (cmd_valid && cmd_ready) begin
                hs++;
                hs_cyc = i;
            end
            step();
            if (hs == 1) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        et = put_byte(put_byte('1, 0, 8'h30, 20), 201, 8'hFF, 20);
        checks++; if (tv !== et) $display("FAIL b2b_wave: got %h want %h", tv, et); else passed++;
        checks++; if (hs != 1) $display("FAIL b2b_handshakes: got %0d want 1", hs); else passed++;
        checks++; if (hs_cyc != 200) $display("FAIL b2b_hs_cycle: got %0d want 200", hs_cyc); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_end: busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [511:0] tv, bv, ev, et;
        send_req(3'd1, 3'd0, 4'd1, 4'd1);
        repeat (90) step();
        checks++; if (uart_tx !== 1'b0 || busy !== 1'b1)
            $display("FAIL mid_bit3: tx=%b busy=%b want 0/1", uart_tx, busy); else passed++;
        reset = 1'b1;
        step();
        checks++; if (uart_tx !== 1'b1) $display("FAIL mid_reset_tx: got %b want 1", uart_tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL mid_reset_err: got %b want 0", err); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL mid_reset_ready: got %b want 0", cmd_ready); else passed++;
        reset = 1'b0;
        step();
        send_req(3'd4, 3'd0, 4'd0, 4'd0);
        capture(200, 1'b0, tv, bv, ev);
        et = put_byte('1, 0, 8'hFF, 20);
        checks++; if (tv !== et) $display("FAIL mid_resync_wave: got %h want %h", tv, et); else passed++;
        send_req(3'd0, 3'b010, 4'd0, 4'd0);
        capture(200, 1'b0, tv, bv, ev);
        et = put_byte('1, 0, 8'h02, 20);
        checks++; if (tv !== et) $display("FAIL mid_rgb_wave: got %h want %h", tv, et); else passed++;
    endtask

    task automatic test_cpb2();
        logic [511:0] tv, bv, ev, et;
        send_req(3'd0, 3'b111, 4'd0, 4'd0);
        capture(20, 1'b1, tv, bv, ev);
        et = put_byte('1, 0, 8'h07, 2);
        checks++; if (tv !== et) $display("FAIL cpb2_wave: got %h want %h", tv, et); else passed++;
        checks++; if (bv !== ones(20)) $display("FAIL cpb2_busy: got %h want %h", bv, ones(20)); else passed++;
        checks++; if (ev !== '0) $display("FAIL cpb2_err: got %h want 0", ev); else passed++;
        checks++; if (busy2 !== 1'b0 || ready2 !== 1'b1 || tx2 !== 1'b1)
            $display("FAIL cpb2_done: busy=%b ready=%b tx=%b want 0/1/1", busy2, ready2, tx2); else passed++;
    endtask

    initial begin
        test_reset();
        test_set_rgb();
        test_set_pixel();
        test_reject();
        test_back_to_back();
        test_reset_mid_frame();
        test_cpb2();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/led_panel_cmd_tx.md
# led_panel_cmd_tx

Command transmitter for the single LED panel. It accepts high-level drawing requests over a valid/ready handshake and encodes each one into the panel's byte command protocol:
- 0x0R: set colour
- 0x10 + pixel byte: set pixel
- 0x20 + pixel byte: clear pixel
- 0x30: clear screen
- 0xFF: resync

It then serialises the bytes as 8N1 UART on `uart_tx`. It sits on the host/controller side and drives the panel's `uart_data` input. It can also be looped back to the panel receiver on the same die for self-test.

## Interface
- `CLKS_PER_BIT`, default 20: clock cycles per UART bit. Must match the panel receiver. Legal range 2..65535.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: request present.
- `cmd_ready` out 1: block can accept a request this cycle.
- `cmd_op` in 3: operation code.
  - 0 = SET_RGB
  - 1 = SET_PIXEL
  - 2 = CLR_PIXEL
  - 3 = CLEAR_SCREEN
  - 4 = RESYNC
  - 5..7 = reserved
- `cmd_rgb` in 3: colour {r,g,b}. Used by SET_RGB only.
- `cmd_col` in 4: pixel column (frame-buffer word index). Used by SET/CLR_PIXEL.
- `cmd_row` in 4: pixel row (bit index). Used by SET/CLR_PIXEL.
- `uart_tx` out 1: serial line. Idle high.
- `busy` out 1: a byte sequence is in progress.
- `err` out 1: one-cycle pulse when a request is rejected.

## Operation
- Handshake: a request is accepted on any rising edge with `cmd_valid & cmd_ready`. All `cmd_*` fields are sampled into internal registers at acceptance. Inputs are don't-care at other times.
- Encoding, first byte then optional second byte:
  - SET_RGB: {5'b00000, `cmd_rgb`}.
  - SET_PIXEL: 0x10, then {`cmd_col`, `cmd_row`}.
  - CLR_PIXEL: 0x20, then {`cmd_col`, `cmd_row`}.
  - CLEAR_SCREEN: 0x30.
  - RESYNC: 0xFF. This returns the receiver to its control state from any state without writing a pixel.
- Rejections: the request is accepted (handshake completes), no bytes are sent, and `err` pulses.
  - Reserved op (5..7).
  - SET/CLR_PIXEL with col=15, row=15. Pixel byte 0xFF is discarded by the receiver, so this pixel cannot be addressed.
- FSM states:
  - IDLE: `cmd_ready`=1, `uart_tx`=1.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each `CLKS_PER_BIT` cycles.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles.
- Transitions:
  - IDLE → START on a valid, non-rejected acceptance.
  - START → DATA, DATA → STOP, as each bit period completes.
  - STOP → START when a second byte is pending; otherwise STOP → IDLE.
- Counters:
  - Bit-period counter: 16 bits, 0..`CLKS_PER_BIT`-1.
  - Bit index: 3 bits, wraps 7→0 at the DATA→STOP exit.
  - Byte index: 1 bit.
- `busy` = (state != IDLE). `cmd_ready` = (state == IDLE) & !reset.
- Reset values: `uart_tx`=1, `busy`=0, `err`=0, `cmd_ready`=0 while reset is asserted, state=IDLE, all counters 0.
- Reset mid-frame: on the next edge `uart_tx` returns high and the current sequence is abandoned. The receiver may see a corrupt byte or be left waiting for a pixel byte. Software must issue RESYNC after any such reset.

## Timing
- Acceptance at edge t: `uart_tx` falls at t+1 (start bit), so latency is 1 cycle.
- One byte occupies exactly 10·`CLKS_PER_BIT` cycles: start, 8 data, stop.
- Two-byte commands: the second start bit begins immediately after the first stop bit's last cycle, with no idle gap. Total 20·`CLKS_PER_BIT` cycles.
- `cmd_ready` rises in the first cycle after the final stop bit ends.
  - A request held valid is accepted on that same edge.
  - Its start bit follows 1 cycle later, so the inter-command idle time is exactly 1 cycle.
- Rejected request at edge t:
  - `err`=1 during cycle t+1 only.
  - State stays IDLE and `cmd_ready` stays 1, so a rejected request followed by a valid one is accepted on the very next edge.
  - `uart_tx` remains high throughout.
- `err` never asserts during a valid transfer.

## Test plan
- Reset, then SET_RGB rgb=3'b101 → `uart_tx` low at t+1 for 20 cycles, then bits 1,0,1,0,0,0,0,0 at 20 cycles each, then high. `busy` is high for 200 cycles. `cmd_ready` returns at t+201.
- SET_PIXEL col=14 row=2 → bytes 0x10 then 0xE2, back-to-back, 400 cycles total. Loopback into the panel receiver sets frame_buffer[14][2]=1.
- SET_PIXEL col=15 row=15, and separately op=6 → each gives an `err` pulse of exactly 1 cycle. `uart_tx` stays high and `cmd_ready` stays 1. A following CLEAR_SCREEN is accepted on the next edge and sends 0x30.
- Valid held high for CLEAR_SCREEN then RESYNC → 0x30, a 1-cycle idle, then 0xFF. Both handshakes occur exactly when `cmd_ready`=1 and no request is lost or duplicated.
- Reset asserted during data bit 3 of 0x10 → `uart_tx`=1, `busy`=0, `err`=0 after one edge. After release, RESYNC then SET_RGB 3'b010 in loopback leaves the receiver rgb=3'b010 with no pixel changed.
- `CLKS_PER_BIT`=2 build: an SET_RGB byte 0x07 completes in 20 cycles with correct bit order.
